// File: rtl/terasic_clock_check_pkg.sv
// Shared definitions for the clock-check master: slave register map,
// sequencer state encoding and the argument sanity check.
package terasic_clock_check_pkg;

  localparam logic [1:0] REG_START = 2'd0;
  localparam logic [1:0] REG_CLK1  = 2'd1;
  localparam logic [1:0] REG_CLK2  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ARGCHK   = 4'd1,
    ST_WR_START = 4'd2,
    ST_GAP      = 4'd3,
    ST_RD_STAT  = 4'd4,
    ST_CHK_STAT = 4'd5,
    ST_ABORT    = 4'd6,
    ST_SETTLE   = 4'd7,
    ST_RD_C1    = 4'd8,
    ST_CAP_C1   = 4'd9,
    ST_RD_C2    = 4'd10,
    ST_CAP_C2   = 4'd11,
    ST_EVAL     = 4'd12,
    ST_DONE     = 4'd13
  } state_e;

  // A zero window never terminates usefully, and an inverted range can never pass.
  function automatic logic args_bad(input logic [15:0] window,
                                    input logic [15:0] c1_min, input logic [15:0] c1_max,
                                    input logic [15:0] c2_min, input logic [15:0] c2_max);
    return (window == 16'd0) || (c1_min > c1_max) || (c2_min > c2_max);
  endfunction

endpackage

// File: rtl/clock_range_check.sv
// Inclusive range comparator for one captured clock count.
module clock_range_check (
  input  logic [15:0] count_i,
  input  logic [15:0] min_i,
  input  logic [15:0] max_i,
  output logic        ok_o
);

  assign ok_o = (count_i >= min_i) && (count_i <= max_i);

endmodule

// File: rtl/terasic_clock_check_master.sv
// Avalon-MM master that runs one clock-count measurement on the slave:
// program the window, poll status, settle, read both counts, range-check.
module terasic_clock_check_master
  import terasic_clock_check_pkg::*;
#(
  parameter int POLL_GAP      = 8,
  parameter int POLL_LIMIT    = 4096,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        s_clk_in,
  input  logic        s_reset_n_in,
  input  logic        start_in,
  input  logic [15:0] window_in,
  input  logic [15:0] clk1_min_in,
  input  logic [15:0] clk1_max_in,
  input  logic [15:0] clk2_min_in,
  input  logic [15:0] clk2_max_in,
  output logic [1:0]  m_address_out,
  output logic        m_read_out,
  output logic        m_write_out,
  output logic [31:0] m_writedata_out,
  input  logic [31:0] m_readdata_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [15:0] clk1_count_out,
  output logic [15:0] clk2_count_out,
  output logic        clk1_ok_out,
  output logic        clk2_ok_out,
  output logic        timeout_out,
  output logic        arg_err_out
);

  localparam int WAIT_MAX = (POLL_GAP > SETTLE_CYCLES) ? POLL_GAP : SETTLE_CYCLES;
  localparam int WW       = $clog2(WAIT_MAX + 1);
  localparam int PW       = $clog2(POLL_LIMIT + 1);
  localparam logic [WW-1:0] GAP_LAST    = WW'(POLL_GAP - 1);
  localparam logic [WW-1:0] SETTLE_LAST = WW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST   = PW'(POLL_LIMIT);

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [PW-1:0]   poll_q, poll_d;
  logic [15:0]     window_q, window_d;
  logic [15:0]     c1_min_q, c1_min_d, c1_max_q, c1_max_d;
  logic [15:0]     c2_min_q, c2_min_d, c2_max_q, c2_max_d;
  logic [15:0]     count1_q, count1_d, count2_q, count2_d;
  logic            ok1_q, ok1_d, ok2_q, ok2_d;
  logic            timeout_q, timeout_d, arg_err_q, arg_err_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            m_read_q, m_read_d, m_write_q, m_write_d;
  logic [1:0]      m_addr_q, m_addr_d;
  logic [31:0]     m_wdata_q, m_wdata_d;
  logic            clk1_ok_s, clk2_ok_s;
  logic            unused_rdata_s;

  // Upper status/count bits carry nothing this master needs.
  assign unused_rdata_s = ^m_readdata_in[31:16];

  clock_range_check u_clk1_check (
    .count_i (count1_q),
    .min_i   (c1_min_q),
    .max_i   (c1_max_q),
    .ok_o    (clk1_ok_s)
  );

  clock_range_check u_clk2_check (
    .count_i (count2_q),
    .min_i   (c2_min_q),
    .max_i   (c2_max_q),
    .ok_o    (clk2_ok_s)
  );

  // Sequencer next state, datapath updates, and bus strobes decoded from the next state.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    poll_d    = poll_q;
    window_d  = window_q;
    c1_min_d  = c1_min_q;
    c1_max_d  = c1_max_q;
    c2_min_d  = c2_min_q;
    c2_max_d  = c2_max_q;
    count1_d  = count1_q;
    count2_d  = count2_q;
    ok1_d     = ok1_q;
    ok2_d     = ok2_q;
    timeout_d = timeout_q;
    arg_err_d = arg_err_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          window_d  = window_in;
          c1_min_d  = clk1_min_in;
          c1_max_d  = clk1_max_in;
          c2_min_d  = clk2_min_in;
          c2_max_d  = clk2_max_in;
          count1_d  = 16'd0;
          count2_d  = 16'd0;
          ok1_d     = 1'b0;
          ok2_d     = 1'b0;
          timeout_d = 1'b0;
          arg_err_d = 1'b0;
          poll_d    = '0;
          state_d   = ST_ARGCHK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARGCHK: begin
        if (args_bad(window_q, c1_min_q, c1_max_q, c2_min_q, c2_max_q)) begin
          arg_err_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_WR_START;
        end
      end
      ST_WR_START: state_d = ST_GAP;
      ST_GAP: begin
        if (wait_q == GAP_LAST) begin
          state_d = ST_RD_STAT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_RD_STAT: begin
        poll_d  = poll_q + PW'(1);
        state_d = ST_CHK_STAT;
      end
      ST_CHK_STAT: begin
        if (!m_readdata_in[0]) begin
          state_d = ST_SETTLE;
        end else if (poll_q == POLL_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_ABORT;
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_ABORT: state_d = ST_DONE;
      ST_SETTLE: begin
        if (wait_q == SETTLE_LAST) begin
          state_d = ST_RD_C1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      ST_RD_C1: state_d = ST_CAP_C1;
      ST_CAP_C1: begin
        count1_d = m_readdata_in[15:0];
        state_d  = ST_RD_C2;
      end
      ST_RD_C2: state_d = ST_CAP_C2;
      ST_CAP_C2: begin
        count2_d = m_readdata_in[15:0];
        state_d  = ST_EVAL;
      end
      ST_EVAL: begin
        ok1_d   = clk1_ok_s;
        ok2_d   = clk2_ok_s;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    m_read_d  = 1'b0;
    m_write_d = 1'b0;
    m_addr_d  = REG_START;
    m_wdata_d = 32'd0;
    case (state_d)
      ST_WR_START: begin
        m_write_d = 1'b1;
        m_wdata_d = {16'h0000, window_q};
      end
      ST_ABORT:   m_write_d = 1'b1;
      ST_RD_STAT: m_read_d  = 1'b1;
      ST_RD_C1: begin
        m_read_d = 1'b1;
        m_addr_d = REG_CLK1;
      end
      ST_RD_C2: begin
        m_read_d = 1'b1;
        m_addr_d = REG_CLK2;
      end
      default: m_read_d = 1'b0;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and registered outputs; reset abandons any bus activity.
  always_ff @(posedge s_clk_in or negedge s_reset_n_in) begin
    if (!s_reset_n_in) begin
      state_q   <= ST_IDLE;
      wait_q    <= '0;
      poll_q    <= '0;
      window_q  <= 16'd0;
      c1_min_q  <= 16'd0;
      c1_max_q  <= 16'd0;
      c2_min_q  <= 16'd0;
      c2_max_q  <= 16'd0;
      count1_q  <= 16'd0;
      count2_q  <= 16'd0;
      ok1_q     <= 1'b0;
      ok2_q     <= 1'b0;
      timeout_q <= 1'b0;
      arg_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= 2'd0;
      m_wdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      poll_q    <= poll_d;
      window_q  <= window_d;
      c1_min_q  <= c1_min_d;
      c1_max_q  <= c1_max_d;
      c2_min_q  <= c2_min_d;
      c2_max_q  <= c2_max_d;
      count1_q  <= count1_d;
      count2_q  <= count2_d;
      ok1_q     <= ok1_d;
      ok2_q     <= ok2_d;
      timeout_q <= timeout_d;
      arg_err_q <= arg_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_address_out   = m_addr_q;
  assign m_read_out      = m_read_q;
  assign m_write_out     = m_write_q;
  assign m_writedata_out = m_wdata_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign clk1_count_out  = count1_q;
  assign clk2_count_out  = count2_q;
  assign clk1_ok_out     = ok1_q;
  assign clk2_ok_out     = ok2_q;
  assign timeout_out     = timeout_q;
  assign arg_err_out     = arg_err_q;

endmodule

// File: tb/tb_terasic_clock_check_master.sv
// Bench for terasic_clock_check_master: behavioural clock-count slave,
// bus monitor, and a done-driven scoreboard fed by directed runs.
`timescale 1ns/1ps
module tb_terasic_clock_check_master;

  localparam int GAP = 400;
  localparam int LIM = 4;
  localparam int SET = 16;

  logic        s_clk_in = 1'b0;
  logic        s_reset_n_in = 1'b0;
  logic        start_in = 1'b0;
  logic [15:0] window_in = 16'd0;
  logic [15:0] clk1_min_in = 16'd0, clk1_max_in = 16'd0;
  logic [15:0] clk2_min_in = 16'd0, clk2_max_in = 16'd0;
  logic [1:0]  m_address_out;
  logic        m_read_out, m_write_out;
  logic [31:0] m_writedata_out;
  logic [31:0] m_readdata_in = 32'd0;
  logic        busy_out, done_out;
  logic [15:0] clk1_count_out, clk2_count_out;
  logic        clk1_ok_out, clk2_ok_out, timeout_out, arg_err_out;

  terasic_clock_check_master #(
    .POLL_GAP(GAP), .POLL_LIMIT(LIM), .SETTLE_CYCLES(SET)
  ) dut (
    .s_clk_in(s_clk_in), .s_reset_n_in(s_reset_n_in), .start_in(start_in),
    .window_in(window_in), .clk1_min_in(clk1_min_in), .clk1_max_in(clk1_max_in),
    .clk2_min_in(clk2_min_in), .clk2_max_in(clk2_max_in),
    .m_address_out(m_address_out), .m_read_out(m_read_out), .m_write_out(m_write_out),
    .m_writedata_out(m_writedata_out), .m_readdata_in(m_readdata_in),
    .busy_out(busy_out), .done_out(done_out),
    .clk1_count_out(clk1_count_out), .clk2_count_out(clk2_count_out),
    .clk1_ok_out(clk1_ok_out), .clk2_ok_out(clk2_ok_out),
    .timeout_out(timeout_out), .arg_err_out(arg_err_out)
  );

  always #5 s_clk_in = ~s_clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic       clk1 = 1'b0, clk2 = 1'b0;
  logic [1:0] ph = 2'd0;
  bit         clk2_en = 1'b1;
  bit         stuck = 1'b0;
  int         e1 = 0, e2 = 0, base1 = 0, base2 = 0, remaining = 0;
  bit         counting = 1'b0;
  logic [15:0] lat1 = 16'd0, lat2 = 16'd0;

  // measured clocks: CLK1 = s_clk/2, CLK2 = s_clk/4 (optionally held low)
  always @(posedge s_clk_in) begin
    clk1 <= ~clk1;
    ph   <= ph + 2'd1;
    clk2 <= clk2_en ? ph[1] : 1'b0;
  end
  always @(posedge clk1) e1 <= e1 + 1;
  always @(posedge clk2) e2 <= e2 + 1;

  // register file: start/status, window countdown, count latches, latency-1 reads
  always @(posedge s_clk_in) begin
    if (m_write_out && m_address_out == 2'd0) begin
      if (m_writedata_out[15:0] != 16'd0) begin
        remaining <= int'(m_writedata_out[15:0]);
        counting  <= 1'b1;
        base1     <= e1;
        base2     <= e2;
      end else begin
        remaining <= 0;
        counting  <= 1'b0;
      end
    end else if (counting) begin
      if (remaining == 1) begin
        counting <= 1'b0;
        lat1     <= 16'(e1 - base1);
        lat2     <= 16'(e2 - base2);
      end
      remaining <= remaining - 1;
    end
    if (m_read_out) begin
      case (m_address_out)
        2'd0:    m_readdata_in <= {31'd0, counting | stuck};
        2'd1:    m_readdata_in <= {16'd0, lat1};
        2'd2:    m_readdata_in <= {16'd0, lat2};
        default: m_readdata_in <= 32'd0;
      endcase
    end
  end

  // ---------------- bus monitor ----------------
  int rd0 = 0, rd1 = 0, rd2 = 0;
  logic [31:0] wlog[$];

  always @(negedge s_clk_in) begin
    if (s_reset_n_in) begin
      if (m_read_out && m_write_out) begin
        total++; bad++;
        $display("FAIL bus_two_strobes: read=%0d write=%0d", m_read_out, m_write_out);
      end
      if (m_write_out) begin
        if (m_address_out != 2'd0) begin
          total++; bad++;
          $display("FAIL write_addr: got %0d expected 0", m_address_out);
        end
        wlog.push_back(m_writedata_out);
      end
      if (m_read_out) begin
        case (m_address_out)
          2'd0:    rd0++;
          2'd1:    rd1++;
          2'd2:    rd2++;
          default: begin total++; bad++; $display("FAIL read_addr: got 3 expected 0..2"); end
        endcase
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] window;
    bit          arg_err;
    bit          timeout;
    bit          ok1;
    bit          ok2;
    logic [15:0] c1;
    logic [15:0] c2;
    int          polls;
  } exp_t;
  exp_t q[$];
  int busy_cnt = 0;

  // pop one expectation per done pulse and compare all results
  always @(negedge s_clk_in) begin
    if (!s_reset_n_in) begin
      busy_cnt = 0;
    end else begin
      if (busy_out && !done_out) busy_cnt++;
      if (done_out) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done with no run pending");
        end else begin
          exp_t e;
          int   lat_exp;
          int   nwr;
          bit   normal;
          e      = q.pop_front();
          normal = !e.arg_err && !e.timeout;
          nwr    = e.arg_err ? 0 : (e.timeout ? 2 : 1);
          if (e.arg_err)      lat_exp = 1;
          else if (e.timeout) lat_exp = 2 + (GAP + 2) * LIM + 1;
          else                lat_exp = 2 + (GAP + 2) * e.polls + SET + 5;
          chk("busy_on_done", busy_out, 1);
          chk("arg_err", arg_err_out, e.arg_err);
          chk("timeout", timeout_out, e.timeout);
          chk("clk1_ok", clk1_ok_out, e.ok1);
          chk("clk2_ok", clk2_ok_out, e.ok2);
          chk("clk1_count", clk1_count_out, e.c1);
          chk("clk2_count", clk2_count_out, e.c2);
          chk("status_reads", rd0, e.polls);
          chk("clk1_reads", rd1, normal ? 1 : 0);
          chk("clk2_reads", rd2, normal ? 1 : 0);
          chk("latency", busy_cnt, lat_exp);
          chk("write_count", wlog.size(), nwr);
          if (wlog.size() >= 1) chk("window_write", wlog[0], {16'h0000, e.window});
          if (e.timeout && wlog.size() >= 2) chk("abort_write", wlog[1], 32'd0);
        end
        busy_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input logic [15:0] w, input logic [15:0] mn1, input logic [15:0] mx1,
                     input logic [15:0] mn2, input logic [15:0] mx2,
                     input bit ea, input bit et, input bit eo1, input bit eo2,
                     input logic [15:0] ec1, input logic [15:0] ec2, input int ep,
                     input bit poke);
    exp_t e;
    bit   seen;
    @(negedge s_clk_in);
    rd0 = 0; rd1 = 0; rd2 = 0;
    wlog.delete();
    window_in = w; clk1_min_in = mn1; clk1_max_in = mx1;
    clk2_min_in = mn2; clk2_max_in = mx2;
    start_in = 1'b1;
    e.window = w; e.arg_err = ea; e.timeout = et; e.ok1 = eo1; e.ok2 = eo2;
    e.c1 = ec1; e.c2 = ec2; e.polls = ep;
    q.push_back(e);
    @(negedge s_clk_in);
    start_in = 1'b0;
    // inputs scribbled after acceptance must not influence the run
    window_in = 16'd0; clk1_min_in = 16'hffff; clk1_max_in = 16'd0;
    clk2_min_in = 16'hffff; clk2_max_in = 16'd0;
    seen = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (done_out) begin
        seen = 1'b1;
        break;
      end
      start_in = poke && (i == 3 || i == 400 || i == 1000);
      @(negedge s_clk_in);
    end
    start_in = 1'b0;
    if (!seen) begin
      chk("done_seen", 0, 1);
      q.delete();
    end else if (poke) begin
      window_in = 16'd100; clk1_min_in = 16'd0; clk1_max_in = 16'd100;
      clk2_min_in = 16'd0; clk2_max_in = 16'd100;
      start_in = 1'b1;
      @(negedge s_clk_in);
      start_in = 1'b0;
      wlog.delete();
      repeat (10) @(negedge s_clk_in);
      chk("start_on_done_busy", busy_out, 0);
      chk("start_on_done_writes", wlog.size(), 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge s_clk_in);
    chk("reset_outputs",
        |{m_address_out, m_read_out, m_write_out, m_writedata_out, busy_out, done_out,
          clk1_count_out, clk2_count_out, clk1_ok_out, clk2_ok_out, timeout_out, arg_err_out}, 0);
    s_reset_n_in = 1'b1;

    // nominal: 1000-cycle window, counts 500 / 250, three status polls
    run(16'd1000, 16'd495, 16'd505, 16'd245, 16'd255, 0, 0, 1, 1, 16'd500, 16'd250, 3, 0);
    // zero window and inverted range: argument error, no bus traffic
    run(16'd0,    16'd495, 16'd505, 16'd245, 16'd255, 1, 0, 0, 0, 16'd0, 16'd0, 0, 0);
    run(16'd1000, 16'd10,  16'd5,   16'd245, 16'd255, 1, 0, 0, 0, 16'd0, 16'd0, 0, 0);
    // dead CLK2: count 0 passes a 0..10 range, fails 1..10
    clk2_en = 1'b0;
    run(16'd200,  16'd90,  16'd110, 16'd0,   16'd10,  0, 0, 1, 1, 16'd100, 16'd0, 1, 0);
    run(16'd200,  16'd90,  16'd110, 16'd1,   16'd10,  0, 0, 1, 0, 16'd100, 16'd0, 1, 0);
    clk2_en = 1'b1;
    // status stuck busy: four polls, stop write, timeout, counts and flags stay 0
    stuck = 1'b1;
    run(16'd50,   16'd0,   16'd100, 16'd0,   16'd100, 0, 1, 0, 0, 16'd0, 16'd0, LIM, 0);
    stuck = 1'b0;
    // start pulses while busy and on the done cycle are ignored
    run(16'd1000, 16'd495, 16'd505, 16'd245, 16'd255, 0, 0, 1, 1, 16'd500, 16'd250, 3, 1);

    // reset while waiting between polls, then a clean rerun
    @(negedge s_clk_in);
    window_in = 16'd1000; clk1_min_in = 16'd495; clk1_max_in = 16'd505;
    clk2_min_in = 16'd245; clk2_max_in = 16'd255;
    start_in = 1'b1;
    @(negedge s_clk_in);
    start_in = 1'b0;
    repeat (50) @(negedge s_clk_in);
    chk("busy_before_reset", busy_out, 1);
    #2 s_reset_n_in = 1'b0;
    #1;
    chk("midrun_reset_outputs",
        |{m_address_out, m_read_out, m_write_out, m_writedata_out, busy_out, done_out,
          clk1_count_out, clk2_count_out, clk1_ok_out, clk2_ok_out, timeout_out, arg_err_out}, 0);
    q.delete();
    wlog.delete();
    repeat (3) @(negedge s_clk_in);
    s_reset_n_in = 1'b1;
    run(16'd1000, 16'd495, 16'd505, 16'd245, 16'd255, 0, 0, 1, 1, 16'd500, 16'd250, 3, 0);

    repeat (5) @(negedge s_clk_in);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
